// File: rtl/tpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tpu_ctrl_pkg
//  Description : Shared definitions for the tile sequencer: state encoding
//                and default widths/stride.
//  Revision    : 1.0  initial release
// ============================================================================
package tpu_ctrl_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_CNT_W      = 4;
    localparam int DEF_TILE_WORDS = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MATMUL = 3'd2,
        S_DRAIN  = 3'd3,
        S_NORM   = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage : tpu_ctrl_pkg
`default_nettype wire

// File: rtl/tile_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tile_sequencer_if
//  Description : Engine-side bundle of the tile sequencer: matmul request and
//                tile addresses, normalization request, and completion flags.
//                master = sequencer, slave = matmul/norm engines.
//  Revision    : 1.0  initial release
// ============================================================================
interface tile_sequencer_if
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              start_mat_mul;
    logic              done_mat_mul;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [ADDR_W-1:0] c_addr;
    logic              accum_clear;
    logic              start_norm;
    logic              done_norm;

    modport master (
        output start_mat_mul, a_addr, b_addr, c_addr, accum_clear, start_norm,
        input  done_mat_mul, done_norm
    );

    modport slave (
        input  start_mat_mul, a_addr, b_addr, c_addr, accum_clear, start_norm,
        output done_mat_mul, done_norm
    );
endinterface : tile_sequencer_if
`default_nettype wire

// File: rtl/tile_loop_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_loop_counter
//  Description : Nested m (outer) / n (middle) / k (inner) tile counter.
//                Ports: clk, reset, clear (sync zero), advance (step once),
//                m/n/k_tiles (loop bounds), k (current inner index),
//                m/n/k_next (values after the next advance), last_k,
//                run_wrap (advancing now wraps all three loops).
//  Revision    : 1.0  initial release
// ============================================================================
module tile_loop_counter
    import tpu_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [CNT_W-1:0] m_tiles,
    input  logic [CNT_W-1:0] n_tiles,
    input  logic [CNT_W-1:0] k_tiles,
    output logic [CNT_W-1:0] k,
    output logic [CNT_W-1:0] m_next,
    output logic [CNT_W-1:0] n_next,
    output logic [CNT_W-1:0] k_next,
    output logic             last_k,
    output logic             run_wrap
);
    logic [CNT_W-1:0] r_m, r_n, r_k;
    logic             w_last_n, w_last_m;

    assign last_k   = (r_k == k_tiles - CNT_W'(1));
    assign w_last_n = (r_n == n_tiles - CNT_W'(1));
    assign w_last_m = (r_m == m_tiles - CNT_W'(1));
    assign run_wrap = last_k && w_last_n && w_last_m;
    assign k        = r_k;

    // Each level only moves when every inner level wraps on this step.
    always_comb begin
        k_next = last_k ? '0 : r_k + CNT_W'(1);
        n_next = r_n;
        m_next = r_m;
        if (last_k) begin
            n_next = w_last_n ? '0 : r_n + CNT_W'(1);
            if (w_last_n) begin
                m_next = w_last_m ? '0 : r_m + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_m <= '0;
            r_n <= '0;
            r_k <= '0;
        end else if (advance) begin
            r_m <= m_next;
            r_n <= n_next;
            r_k <= k_next;
        end
    end
endmodule : tile_loop_counter
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_sequencer
//  Description : Walks an M x N x K tile loop, issuing a matmul per tile step
//                with registered A/B/C addresses, and a normalization after
//                the last k-step of every output tile.
//                Ports: clk, reset (sync, active-high), start (level run
//                enable), cfg_* (tile counts and base addresses, captured in
//                LOAD), busy, done_all, bus (engine handshakes/addresses).
//  Revision    : 1.0  initial release
// ============================================================================
module tile_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TILE_WORDS = DEF_TILE_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_m_tiles,
    input  logic [CNT_W-1:0]  cfg_n_tiles,
    input  logic [CNT_W-1:0]  cfg_k_tiles,
    input  logic [ADDR_W-1:0] cfg_a_base,
    input  logic [ADDR_W-1:0] cfg_b_base,
    input  logic [ADDR_W-1:0] cfg_c_base,
    output logic              busy,
    output logic              done_all,
    tile_sequencer_if.master  bus
);
    state_t            r_state, w_state_nx;

    logic [CNT_W-1:0]  r_m_tiles, r_n_tiles, r_k_tiles;
    logic [ADDR_W-1:0] r_a_base, r_b_base, r_c_base;
    logic [ADDR_W-1:0] r_a_addr, r_b_addr, r_c_addr;
    logic [ADDR_W-1:0] w_a_off, w_b_off, w_c_off;

    logic [CNT_W-1:0]  w_k, w_m_nx, w_n_nx, w_k_nx;
    logic              w_last_k, w_run_wrap, w_cfg_zero;

    assign w_cfg_zero = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);

    tile_loop_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    ((r_state == S_IDLE) || !start),
        .advance  ((r_state == S_NEXT) && start),
        .m_tiles  (r_m_tiles),
        .n_tiles  (r_n_tiles),
        .k_tiles  (r_k_tiles),
        .k        (w_k),
        .m_next   (w_m_nx),
        .n_next   (w_n_nx),
        .k_next   (w_k_nx),
        .last_k   (w_last_k),
        .run_wrap (w_run_wrap)
    );

    // Offsets use the post-advance indices so the registers hold the new
    // tile's addresses from the first MATMUL cycle. Arithmetic is done at
    // ADDR_W bits, giving the required modulo-2^ADDR_W wrap.
    assign w_a_off = (ADDR_W'(w_m_nx) * ADDR_W'(r_k_tiles) + ADDR_W'(w_k_nx)) * ADDR_W'(TILE_WORDS);
    assign w_b_off = (ADDR_W'(w_k_nx) * ADDR_W'(r_n_tiles) + ADDR_W'(w_n_nx)) * ADDR_W'(TILE_WORDS);
    assign w_c_off = (ADDR_W'(w_m_nx) * ADDR_W'(r_n_tiles) + ADDR_W'(w_n_nx)) * ADDR_W'(TILE_WORDS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nx = S_LOAD;
            S_LOAD:   w_state_nx = w_cfg_zero ? S_DONE : S_MATMUL;
            S_MATMUL: if (bus.done_mat_mul) w_state_nx = S_DRAIN;
            S_DRAIN:  if (!bus.done_mat_mul) w_state_nx = w_last_k ? S_NORM : S_NEXT;
            S_NORM:   if (bus.done_norm) w_state_nx = S_NEXT;
            S_NEXT:   w_state_nx = w_run_wrap ? S_DONE : S_MATMUL;
            S_DONE:   w_state_nx = S_DONE;
            default:  w_state_nx = S_IDLE;
        endcase
        // Dropping start aborts from any state, discarding in-flight requests.
        if (!start) w_state_nx = S_IDLE;
    end

    // Configuration is sampled while in LOAD, i.e. the value present on the
    // edge that leaves LOAD; later changes are ignored for this run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_tiles <= '0;
            r_n_tiles <= '0;
            r_k_tiles <= '0;
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_c_base  <= '0;
        end else if (r_state == S_LOAD) begin
            r_m_tiles <= cfg_m_tiles;
            r_n_tiles <= cfg_n_tiles;
            r_k_tiles <= cfg_k_tiles;
            r_a_base  <= cfg_a_base;
            r_b_base  <= cfg_b_base;
            r_c_base  <= cfg_c_base;
        end
    end

    // Addresses load only on MATMUL entry, so they stay put through
    // MATMUL/DRAIN/NORM. The first tile (m=n=k=0) sits exactly on the bases.
    always_ff @(posedge clk) begin
        if (reset || !start) begin
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_addr <= '0;
        end else if ((r_state == S_LOAD) && (w_state_nx == S_MATMUL)) begin
            r_a_addr <= cfg_a_base;
            r_b_addr <= cfg_b_base;
            r_c_addr <= cfg_c_base;
        end else if ((r_state == S_NEXT) && (w_state_nx == S_MATMUL)) begin
            r_a_addr <= r_a_base + w_a_off;
            r_b_addr <= r_b_base + w_b_off;
            r_c_addr <= r_c_base + w_c_off;
        end
    end

    assign bus.a_addr        = r_a_addr;
    assign bus.b_addr        = r_b_addr;
    assign bus.c_addr        = r_c_addr;
    assign bus.start_mat_mul = (r_state == S_MATMUL);
    assign bus.accum_clear   = (r_state == S_MATMUL) && (w_k == '0);
    assign bus.start_norm    = (r_state == S_NORM);
    assign busy              = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_all          = (r_state == S_DONE);

endmodule : tile_sequencer
`default_nettype wire
